// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// small op-class helpers used by both the sequencer and the arithmetic block.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Multi-cycle ops: the ones that occupy the unit and raise busy.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for the
// latched op and flags divide-by-zero so the sequencer can skip the commit.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_b_safe;
  logic [31:0] quo;
  logic [31:0] rem;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide runs on magnitudes; 0x80000000 has magnitude 0x80000000
  // as an unsigned value, so the overflow case falls out without a trap.
  assign a_neg      = A[31];
  assign b_neg      = B[31];
  assign a_mag      = a_neg ? (32'd0 - A) : A;
  assign b_mag      = b_neg ? (32'd0 - B) : B;
  assign div_a      = (op == MDU_DIV) ? a_mag : A;
  assign div_b      = (op == MDU_DIV) ? b_mag : B;
  assign div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
  assign quo        = div_a / div_b_safe;
  assign rem        = div_a % div_b_safe;
  assign div0       = is_div_op(op) && (B == 32'd0);

  // Select the result pair for the current op; non-arith ops produce zero.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MDU_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
      end
      MDU_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
      end
      MDU_DIV: begin
        lo_res = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
        hi_res = a_neg ? (32'd0 - rem) : rem;
      end
      MDU_DIVU: begin
        lo_res = quo;
        hi_res = rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer beside the EX-stage ALU. Accepts MDU ops, holds
// busy for a fixed latency per op class, then commits the result into HI/LO.
// MTHI/MTLO write immediately; MFHI/MFLO read through rdata.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic             load;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;
  logic [31:0]      hi_res;
  logic [31:0]      lo_res;
  logic             div0;

  // Result is always derived from the operands captured at start, so EX may
  // move on to other instructions while the op is running.
  mdu_arith u_arith (
    .op     (op_q),
    .A      (a_q),
    .B      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  // Next-state, counter and write-enable decode; starts are only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(MDUOp)) begin
            load    = 1'b1;
            cnt_d   = is_div_op(MDUOp) ? DIV_LOAD : MULT_LOAD;
            state_d = ST_RUN;
          end else if (MDUOp == MDU_MTHI) begin
            wr_hi = 1'b1;
          end else if (MDUOp == MDU_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latency counter; reset abandons any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order between processes.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture at the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: operands are reset too, so the arith block never sees X after
      // reset even though its output is only used on commit.
      op_q <= MDU_MULT;
      a_q  <= '0;
      b_q  <= '0;
    end else if (load) begin
      op_q <= MDUOp;
      a_q  <= A;
      b_q  <= B;
    end
  end

  // Architectural HI/LO: commit on completion (skipped on divide-by-zero), or MTxx write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HI <= '0;
      LO <= '0;
    end else if (commit) begin
      if (!div0) begin
        HI <= hi_res;
        LO <= lo_res;
      end
    end else begin
      if (wr_hi) HI <= A;
      if (wr_lo) LO <= A;
    end
  end

  assign busy = (state_q == ST_RUN);

  // MFHI/MFLO read port; returns committed values, so pre-op data during RUN.
  always_comb begin
    rdata = 32'd0;
    if (MDUOp == MDU_MFHI)      rdata = HI;
    else if (MDUOp == MDU_MFLO) rdata = LO;
  end

endmodule
